multi_chan_fifo: RTL and testbench
==================================

# multi_chan_fifo

Parametrised successor of the team's single-queue FIFO: one storage block holding `CHANNELS` independent first-word-fall-through queues, each `FIFO_LENGTH` deep and `DATA_BITS` wide, behind one write port and one read port with channel selects. It sits between multiplexed producers and consumers in a single clock domain. It reports per-channel empty, full and almost-full, the occupancy of the selected read channel, and optional sticky error flags.

## Interface
- `DATA_BITS`, 11, entry width.
- `FIFO_LENGTH`, 16, depth per channel; must be a power of 2 and at least 2.
- `CHANNELS`, 4, number of independent queues, at least 1.
- `AF_MARGIN`, 2, almost-full threshold; `almost_full[c]` is high when the count is at least `FIFO_LENGTH - AF_MARGIN`.
- Derived widths: `CH_BITS = max(1, $clog2(CHANNELS))`, `CNT_BITS = $clog2(FIFO_LENGTH) + 1`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `write`  in  1  write request.
- `write_chan`  in  `CH_BITS`  target channel of the write.
- `input_data`  in  `DATA_BITS`  write data.
- `read`  in  1  pop request.
- `read_chan`  in  `CH_BITS`  channel being read and observed.
- `output_data`  out  `DATA_BITS`  head entry of `read_chan` (FWFT).
- `read_count`  out  `CNT_BITS`  occupancy of `read_chan`.
- `empty`  out  `CHANNELS`  per-channel empty.
- `full`  out  `CHANNELS`  per-channel full.
- `almost_full`  out  `CHANNELS`  per-channel almost-full.
- `overflow`  out  `CHANNELS`  sticky write-when-full flag (see Configuration).
- `underflow`  out  `CHANNELS`  sticky read-when-empty flag (see Configuration).

## Operation
- **Pointers:** each channel has a `wr_ptr` and `rd_ptr`, each `CNT_BITS` wide. The low bits index that channel's region of the memory; the MSB is the wrap bit.
- **Count and flags:** count = `wr_ptr - rd_ptr` (modulo 2^`CNT_BITS`). `empty` means the pointers are equal. `full` means the MSBs differ and the low bits are equal.
- **Write acceptance:** a write is accepted when `write` is high, `write_chan < CHANNELS` and `full[write_chan]` was low before the edge. On acceptance, `input_data` is stored and `wr_ptr` increments; it wraps naturally.
- **Read acceptance:** a read is accepted when `read` is high, `read_chan < CHANNELS` and `empty[read_chan]` was low before the edge. On acceptance, `rd_ptr` increments.
- **Acceptance timing:** both decisions use pre-edge flags only.
  - Read and write to the same full channel: the read is accepted, the write is rejected, and the count drops by 1.
  - Read and write to the same empty channel: the write is accepted, the read is ignored, and the count becomes 1.
  - Read and write to the same channel, neither full nor empty: both are accepted and the count is unchanged.
  - Different channels: both proceed independently.
- **Output data:** `output_data` is a combinational read of the head of `read_chan`. It is 0 when `empty[read_chan]` is high or `read_chan >= CHANNELS`. `read_count` is 0 for an out-of-range channel.
- **Rejected operations** never modify pointers or memory.
- **Reset (asynchronous, any time including mid-transfer):**
  - All pointers clear, so every `empty` bit is 1 and `full`, `almost_full` and `read_count` are 0.
  - `output_data` is 0, and `overflow`/`underflow` are 0.
  - Memory contents are not reset; they are never visible while the channel is empty.

## Timing
- Write-to-visible latency is 1 cycle. After the accepting edge, `empty` falls and `output_data` shows the entry in the same cycle, provided `read_chan` selects that channel.
- A pop takes effect at the accepting edge; the next entry (or 0 and `empty` = 1) is visible immediately after that edge.
- `full` and `almost_full` update after the edge that changes the count; there is no early warning beyond `AF_MARGIN`.
- `read_count` and `output_data` follow `read_chan` combinationally, with no cycle penalty for switching channels.
- Sustained rate: one write and one read per cycle.

## Configuration
- The macro `MULTI_CHAN_FIFO_ERR_EN` controls the error flags.
- **Defined:**
  - `overflow[c]` sets on any cycle where `write` is high, `write_chan == c` and `full[c]` is high.
  - `underflow[c]` sets on any cycle where `read` is high, `read_chan == c` and `empty[c]` is high.
  - Both flags are sticky until reset.
- **Undefined:** both ports exist but are tied to 0, and no error logic is synthesised.

## Test plan
- **Reset defaults:** hold `reset` = 0 for 3 cycles, then release -> `empty` = all ones, `full` = 0, `read_count` = 0, `output_data` = 0.
- **Single-channel fill and drain:** write 0..15 to channel 1 -> `almost_full[1]` rises after the 14th write and `full[1]` after the 16th. Read 16 times -> `output_data` sequence 0..15, then `empty[1]` = 1.
- **Channel isolation:** interleave writes of 100+i to channel 0 and 200+i to channel 3 (i = 0..4) -> reading channel 3 returns 200..204 and channel 0's `read_count` stays 5.
- **Simultaneous access:**
  - Full channel 2 with read and write of 0x7FF -> count drops to 15 and 0x7FF is not stored.
  - Empty channel 0 with write of 5 and read together -> count becomes 1 and `output_data` = 5.
- **Wrap-around:** 40 write/read pairs on channel 1 at steady count 3 -> data stays in order and `full` never asserts.
- **Errors and mid-stream reset:** with the macro defined, write to a full channel and read an empty one -> the matching `overflow`/`underflow` bits set and hold. Assert `reset` mid-stream -> all flags and counts return to reset values asynchronously.

Source files
------------

// File: rtl/multi_chan_fifo.sv
// Multi-channel first-word-fall-through FIFO: CHANNELS independent queues in one memory.
// Define MULTI_CHAN_FIFO_ERR_EN to enable the sticky overflow/underflow flags.
module multi_chan_fifo #(
    parameter int DATA_BITS   = 11,
    parameter int FIFO_LENGTH = 16,
    parameter int CHANNELS    = 4,
    parameter int AF_MARGIN   = 2,
    localparam int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNT_BITS   = $clog2(FIFO_LENGTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [CH_BITS-1:0]   write_chan,
    input  logic [DATA_BITS-1:0] input_data,
    input  logic                 read,
    input  logic [CH_BITS-1:0]   read_chan,
    output logic [DATA_BITS-1:0] output_data,
    output logic [CNT_BITS-1:0]  read_count,
    output logic [CHANNELS-1:0]  empty,
    output logic [CHANNELS-1:0]  full,
    output logic [CHANNELS-1:0]  almost_full,
    output logic [CHANNELS-1:0]  overflow,
    output logic [CHANNELS-1:0]  underflow
);

    localparam int ADDR_BITS = CNT_BITS - 1;
    localparam int MEM_BITS  = CH_BITS + ADDR_BITS;
    localparam int MEM_DEPTH = 1 << MEM_BITS;
    localparam logic [CNT_BITS-1:0] AF_LEVEL = CNT_BITS'(FIFO_LENGTH - AF_MARGIN);

    logic [DATA_BITS-1:0] mem_r    [MEM_DEPTH];
    logic [CNT_BITS-1:0]  wr_ptr_r [CHANNELS];
    logic [CNT_BITS-1:0]  rd_ptr_r [CHANNELS];
    logic [CNT_BITS-1:0]  count_s  [CHANNELS];
    logic [CHANNELS-1:0]  empty_s;
    logic [CHANNELS-1:0]  full_s;
    logic [CHANNELS-1:0]  wr_hit_s;
    logic [CHANNELS-1:0]  rd_hit_s;
    logic [CHANNELS-1:0]  rd_sel_s;
    logic                 wr_accept_s;
    logic [ADDR_BITS-1:0] wr_low_s;
    logic [MEM_BITS-1:0]  wr_addr_s;

    // Per-channel status decode and acceptance; decisions use only pre-edge pointer state.
    always_comb begin
        count_s     = '{default: '0};
        empty_s     = '0;
        full_s      = '0;
        almost_full = '0;
        wr_hit_s    = '0;
        rd_hit_s    = '0;
        rd_sel_s    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            count_s[c]     = wr_ptr_r[c] - rd_ptr_r[c];
            empty_s[c]     = (wr_ptr_r[c] == rd_ptr_r[c]);
            full_s[c]      = (wr_ptr_r[c][CNT_BITS-1] != rd_ptr_r[c][CNT_BITS-1]) &&
                             (wr_ptr_r[c][ADDR_BITS-1:0] == rd_ptr_r[c][ADDR_BITS-1:0]);
            almost_full[c] = (count_s[c] >= AF_LEVEL);
            wr_hit_s[c]    = write && (write_chan == CH_BITS'(c)) && !full_s[c];
            rd_sel_s[c]    = (read_chan == CH_BITS'(c));
            rd_hit_s[c]    = read && rd_sel_s[c] && !empty_s[c];
        end
    end

    assign empty = empty_s;
    assign full  = full_s;

    // Write address: selected channel's region plus its write pointer low bits.
    always_comb begin
        wr_low_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_low_s = wr_low_s | ({ADDR_BITS{wr_hit_s[c]}} & wr_ptr_r[c][ADDR_BITS-1:0]);
        end
        wr_accept_s = |wr_hit_s;
        wr_addr_s   = {write_chan, wr_low_s};
    end

    // Storage array; deliberately not reset since empty channels never expose it.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[wr_addr_s] <= input_data;
        end
    end

    // Pointer registers; the MSB of each pointer is the wrap bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_r[c] <= '0;
                rd_ptr_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_hit_s[c]) begin
                    wr_ptr_r[c] <= wr_ptr_r[c] + CNT_BITS'(1);
                end
                if (rd_hit_s[c]) begin
                    rd_ptr_r[c] <= rd_ptr_r[c] + CNT_BITS'(1);
                end
            end
        end
    end

    // FWFT head and occupancy of the observed channel; zero when empty or out of range.
    always_comb begin
        output_data = '0;
        read_count  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            output_data = output_data |
                          ({DATA_BITS{rd_sel_s[c] & ~empty_s[c]}} &
                           mem_r[{CH_BITS'(c), rd_ptr_r[c][ADDR_BITS-1:0]}]);
            read_count  = read_count | ({CNT_BITS{rd_sel_s[c]}} & count_s[c]);
        end
    end

`ifdef MULTI_CHAN_FIFO_ERR_EN
    logic [CHANNELS-1:0] ovf_set_s;
    logic [CHANNELS-1:0] udf_set_s;
    logic [CHANNELS-1:0] overflow_r;
    logic [CHANNELS-1:0] underflow_r;

    // Error set conditions: any request aimed at a channel that cannot take it.
    always_comb begin
        ovf_set_s = '0;
        udf_set_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ovf_set_s[c] = write && (write_chan == CH_BITS'(c)) && full_s[c];
            udf_set_s[c] = read && rd_sel_s[c] && empty_s[c];
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r  <= '0;
            underflow_r <= '0;
        end else begin
            overflow_r  <= overflow_r | ovf_set_s;
            underflow_r <= underflow_r | udf_set_s;
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    assign overflow  = '0;
    assign underflow = '0;
`endif

endmodule

// File: tb/tb_multi_chan_fifo.sv
// Directed self-checking bench for multi_chan_fifo with per-channel scoreboard queues.
module tb_multi_chan_fifo;

`ifdef MULTI_CHAN_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        write;
    logic [1:0]  write_chan;
    logic [10:0] input_data;
    logic        read;
    logic [1:0]  read_chan;
    logic [10:0] output_data;
    logic [4:0]  read_count;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [3:0]  almost_full;
    logic [3:0]  overflow;
    logic [3:0]  underflow;

    int n_checks;
    int n_fail;
    int q [4][$];
    logic [3:0] ov_m;
    logic [3:0] ud_m;

    multi_chan_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .write_chan  (write_chan),
        .input_data  (input_data),
        .read        (read),
        .read_chan   (read_chan),
        .output_data (output_data),
        .read_count  (read_count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        logic [3:0] e_v, f_v, af_v;
        int rc;
        e_v = 4'h0; f_v = 4'h0; af_v = 4'h0;
        for (int c = 0; c < 4; c++) begin
            e_v[c]  = (q[c].size() == 0);
            f_v[c]  = (q[c].size() == 16);
            af_v[c] = (q[c].size() >= 14);
        end
        rc = int'(read_chan);
        chk("empty", {28'd0, empty}, {28'd0, e_v});
        chk("full", {28'd0, full}, {28'd0, f_v});
        chk("almost_full", {28'd0, almost_full}, {28'd0, af_v});
        chk("read_count", {27'd0, read_count}, q[rc].size());
        chk("head", {21'd0, output_data}, (q[rc].size() > 0) ? q[rc][0] : 32'd0);
        chk("overflow", {28'd0, overflow}, ERR_EN ? {28'd0, ov_m} : 32'd0);
        chk("underflow", {28'd0, underflow}, ERR_EN ? {28'd0, ud_m} : 32'd0);
    endtask

    // One clock of stimulus; the scoreboard decides acceptance from pre-edge occupancy.
    task automatic do_cycle(input bit w, input int wc, input int wd, input bit r, input int rc);
        bit wacc, racc;
        write      = w;
        write_chan = 2'(wc);
        input_data = 11'(wd);
        read       = r;
        read_chan  = 2'(rc);
        #1;
        wacc = w && (q[wc].size() < 16);
        racc = r && (q[rc].size() > 0);
        if (w && q[wc].size() == 16) ov_m[wc] = 1'b1;
        if (r && q[rc].size() == 0) ud_m[rc] = 1'b1;
        if (racc) chk("pop_data", {21'd0, output_data}, q[rc].pop_front());
        if (wacc) q[wc].push_back(wd & 32'h7FF);
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
        #1;
        check_state();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        ov_m = 4'h0; ud_m = 4'h0;
        reset = 1'b0; write = 1'b0; read = 1'b0;
        write_chan = 2'd0; read_chan = 2'd0; input_data = 11'd0;

        // Reset defaults
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_state();
        chk("rst_output", {21'd0, output_data}, 32'd0);

        // Fill and drain channel 1
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 1, i, 1'b0, 1);
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 0, 0, 1'b1, 1);
        chk("ch1_drained", {31'd0, empty[1]}, 32'd1);

        // Channel isolation
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 0, 100 + i, 1'b0, 3);
            do_cycle(1'b1, 3, 200 + i, 1'b0, 3);
        end
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 0, 0, 1'b1, 3);
        do_cycle(1'b0, 0, 0, 1'b0, 0);
        chk("ch0_count", {27'd0, read_count}, 32'd5);

        // Simultaneous access on a full channel, then on an empty one
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 2, 50 + i, 1'b0, 2);
        do_cycle(1'b1, 2, 'h7FF, 1'b1, 2);
        chk("full_rw_count", {27'd0, read_count}, 32'd15);
        for (int i = 0; i < 15; i++) do_cycle(1'b0, 0, 0, 1'b1, 2);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 0, 0, 1'b1, 0);
        do_cycle(1'b1, 0, 5, 1'b1, 0);
        chk("empty_rw_count", {27'd0, read_count}, 32'd1);
        chk("empty_rw_data", {21'd0, output_data}, 32'd5);
        do_cycle(1'b0, 0, 0, 1'b1, 0);

        // Wrap-around at steady occupancy 3
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1, 500 + i, 1'b0, 1);
        for (int i = 0; i < 40; i++) do_cycle(1'b1, 1, 600 + i, 1'b1, 1);
        chk("wrap_count", {27'd0, read_count}, 32'd3);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 0, 0, 1'b1, 1);

        // Overflow on full channel 3, underflow on empty channel 2
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 3, 900 + i, 1'b0, 3);
        do_cycle(1'b1, 3, 1234, 1'b0, 3);
        do_cycle(1'b0, 0, 0, 1'b1, 2);
        do_cycle(1'b0, 0, 0, 1'b0, 3);
        do_cycle(1'b0, 0, 0, 1'b0, 2);

        // Asynchronous reset between clock edges with a write pending
        write = 1'b1; write_chan = 2'd0; input_data = 11'd77; read_chan = 2'd3;
        #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) q[c].delete();
        ov_m = 4'h0; ud_m = 4'h0;
        #1 check_state();
        chk("async_rst_data", {21'd0, output_data}, 32'd0);
        @(posedge clk);
        #1 write = 1'b0; reset = 1'b1;
        #1 check_state();
        do_cycle(1'b1, 3, 42, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
